uart_tx_serializer: RTL
=======================

# uart_tx_serializer

Byte-oriented UART transmitter that consumes the one-cycle start strobe and data byte produced by the payload controller and drives the serial line at a fixed baud rate. It sits directly downstream of the packet sequencer and returns the busy flag that paces chunk transmission. Frame format (parity mode, stop-bit count) is fixed at elaboration. A one-cycle completion pulse is emitted per byte.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bit/s. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, truncating); must be ≥ 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd; any other value behaves as 0.
- STOP_BITS, 1: 1 or 2; any other value behaves as 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- iniciar_envio  in  1  start strobe; sampled only in IDLE.
- dado_entrada  in  8  byte to send; latched on the edge that accepts the strobe.
- tx  out  1  serial line, idle high; registered.
- uart_ocupado  out  1  high from acceptance until the end of the last stop bit; registered.
- byte_enviado  out  1  one-cycle pulse on frame completion.

## Operation
- Reset values: tx = 1, uart_ocupado = 0, byte_enviado = 0, state IDLE, bit counter 0, baud counter 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx = 1. If iniciar_envio = 1: latch dado_entrada into a shift register, compute parity bit (even: XOR of data bits; odd: its inverse), load tx <= 0, uart_ocupado <= 1, baud counter <= 0, go to START. Acceptance and busy assertion occur on the same edge.
- START: hold tx = 0 for CLKS_PER_BIT cycles, then go to DATA with tx = data bit 0.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; 3-bit index counts 0..7. After bit 7 go to PARITY if PARITY ∈ {1,2}, else to STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles. On the last cycle: uart_ocupado <= 0, byte_enviado <= 1 (for one cycle), go to IDLE.
- iniciar_envio while not IDLE: ignored; no queuing; in-flight frame and dado_entrada latch unaffected.
- Changes to dado_entrada after acceptance have no effect on the current frame.
- Baud counter width: clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT-1 on every bit boundary; no cumulative drift.
- Reset mid-frame: tx returns to 1 and uart_ocupado to 0 immediately (asynchronous); the partial frame is abandoned; no byte_enviado pulse.

## Timing
- Strobe sampled at edge E: from E onward, tx = 0 and uart_ocupado = 1. Upstream logic therefore sees busy high on the cycle after its strobe.
- Frame length: F = CLKS_PER_BIT × (1 + 8 + P + STOP_BITS) cycles, where P = 1 if parity is enabled, else 0. uart_ocupado is high for exactly F cycles, starting at E.
- byte_enviado is high in the same cycle in which uart_ocupado first reads 0 again (edge E+F).
- Earliest next acceptance: a strobe sampled at edge E+F. Back-to-back frames therefore have no idle gap beyond the stop bit(s).
- tx is glitch-free: it changes only at bit boundaries, with at most one transition per boundary.

## Test plan
- Reset: assert reset mid-DATA with CLKS_PER_BIT = 4 → tx = 1 and uart_ocupado = 0 within the same cycle; no byte_enviado; next strobe produces a clean frame.
- 8N1, CLK_FREQ = 1_000_000, BAUD_RATE = 250_000, byte 0xAD → tx sequence over 40 cycles is 0,1,0,1,1,0,1,0,1,1 (each bit 4 cycles); busy high for exactly 40 cycles; one byte_enviado pulse at cycle 40.
- PARITY = 1 on 0x07 → parity bit 1, frame 44 cycles; PARITY = 2 on 0x07 → parity bit 0.
- STOP_BITS = 2 on 0x00 → stop high for 8 cycles, busy 44 cycles total.
- Strobe pulses during busy, and dado_entrada changed mid-frame → serialized byte still equals the originally latched value; no second frame.
- Payload-controller handshake: drive a 24-byte packet from the upstream sequencer → the decoded line stream is 0xAD followed by the 23 buffer bytes in order; 24 byte_enviado pulses.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte-level handshake between the payload controller and the UART
// transmitter: start strobe and data in, line, busy and done out.
interface uart_tx_if;
  logic       iniciar_envio;
  logic [7:0] dado_entrada;
  logic       tx;
  logic       uart_ocupado;
  logic       byte_enviado;

  modport master (
    output iniciar_envio,
    output dado_entrada,
    input  tx,
    input  uart_ocupado,
    input  byte_enviado
  );

  modport slave (
    input  iniciar_envio,
    input  dado_entrada,
    output tx,
    output uart_ocupado,
    output byte_enviado
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Fixed-format UART transmitter: start, 8 data bits LSB first,
// optional parity, one or two stop bits, one-cycle done pulse.
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic      clock,
  input  logic      reset,
  uart_tx_if.slave  bus
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CPB - 1);

  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 2);
  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Counter wraps on every bit boundary so bit widths never drift.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.iniciar_envio) begin
          shift_d = bus.dado_entrada;
          par_d   = (^bus.dado_entrada) ^ PAR_ODD;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            if (PAR_EN) begin
              tx_d    = par_q;
              state_d = S_PAR;
            end else begin
              tx_d    = 1'b1;
              stop_d  = 1'b0;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == LAST_STOP) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx           = tx_q;
  assign bus.uart_ocupado = busy_q;
  assign bus.byte_enviado = done_q;

endmodule
